// File: rtl/varredura_setores.sv
// ---------------------------------------------------------------------------
// varredura_setores
//
// Scan controller for reactor sectors. It polls NUM_SETORES sectors in turn
// over one shared sensor bus with a req/ack handshake and compares each sample
// against the control-room thresholds. A sector alarm is raised only after
// CONFIRMA consecutive exceeding samples. A sector that does not answer
// within TIMEOUT cycles is flagged as faulty. Alarm and fault flags stay set
// until the operator acknowledges them.
//
// Ports:
//   clk                 clock, rising edge
//   rst_n               synchronous active-low reset
//   iniciar             level; scanning runs while high
//   req                 sample request to the selected sector (registered)
//   sel_setor           index of the sector being requested
//   ack                 sensor data valid for sel_setor
//   temp/pressao/radiacao  sensor sample (8b / 4b / 12b)
//   reconhecer          operator acknowledge pulse
//   alarme_setor        sticky confirmed-alarm flags, one per sector
//   falha_setor         sticky handshake-timeout flags, one per sector
//   alarme_sonoro       OR of every alarm and fault flag (combinational)
//   varredura_completa  1-cycle pulse after the last sector is processed
// ---------------------------------------------------------------------------
module varredura_setores #(
    parameter int unsigned NUM_SETORES = 4,
    parameter int unsigned LIM_TEMP    = 40,
    parameter int unsigned LIM_PRESSAO = 7,
    parameter int unsigned LIM_RAD     = 1000,
    parameter int unsigned CONFIRMA    = 3,
    parameter int unsigned TIMEOUT     = 15,
    localparam int unsigned SW         = $clog2(NUM_SETORES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iniciar,
    output logic                   req,
    output logic [SW-1:0]          sel_setor,
    input  logic                   ack,
    input  logic [7:0]             temp,
    input  logic [3:0]             pressao,
    input  logic [11:0]            radiacao,
    input  logic                   reconhecer,
    output logic [NUM_SETORES-1:0] alarme_setor,
    output logic [NUM_SETORES-1:0] falha_setor,
    output logic                   alarme_sonoro,
    output logic                   varredura_completa
);

    // Thresholds are compared at the width of the matching sensor port.
    localparam logic [7:0]    LIM_TEMP_W    = 8'(LIM_TEMP);
    localparam logic [3:0]    LIM_PRESSAO_W = 4'(LIM_PRESSAO);
    localparam logic [11:0]   LIM_RAD_W     = 12'(LIM_RAD);
    localparam logic [3:0]    CNT_MAX       = 4'(CONFIRMA);
    localparam logic [7:0]    TIMER_FIM     = 8'(TIMEOUT - 1);
    localparam logic [SW-1:0] ULTIMO_SETOR  = SW'(NUM_SETORES - 1);

    typedef enum logic [1:0] {
        Ocioso,
        Solicita,
        Avalia
    } estado_t;

    estado_t     estado;
    logic [7:0]  timer;
    logic        valido;
    logic [7:0]  temp_cap;
    logic [3:0]  pressao_cap;
    logic [11:0] rad_cap;
    logic [3:0]  cnt [NUM_SETORES];

    logic        excede;
    logic [3:0]  cnt_atual;
    logic [3:0]  cnt_inc;

    assign excede = (temp_cap >= LIM_TEMP_W) | (pressao_cap >= LIM_PRESSAO_W) |
                    (rad_cap >= LIM_RAD_W);

    // Saturating increment of the selected sector's confirmation counter.
    assign cnt_atual = cnt[sel_setor];
    assign cnt_inc   = (cnt_atual < CNT_MAX) ? cnt_atual + 4'd1 : CNT_MAX;

    assign alarme_sonoro = (|alarme_setor) | (|falha_setor);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado             <= Ocioso;
            req                <= 1'b0;
            sel_setor          <= '0;
            timer              <= '0;
            valido             <= 1'b0;
            temp_cap           <= '0;
            pressao_cap        <= '0;
            rad_cap            <= '0;
            alarme_setor       <= '0;
            falha_setor        <= '0;
            varredura_completa <= 1'b0;
            for (int unsigned s = 0; s < NUM_SETORES; s++) begin
                cnt[s] <= '0;
            end
        end else begin
            varredura_completa <= 1'b0;

            // Acknowledge is applied first so that any flag set below in the
            // same cycle overrides the clear.
            if (reconhecer) begin
                falha_setor <= '0;
                for (int unsigned s = 0; s < NUM_SETORES; s++) begin
                    if (cnt[s] < CNT_MAX) begin
                        alarme_setor[s] <= 1'b0;
                    end
                end
            end

            case (estado)
                Ocioso: begin
                    req       <= 1'b0;
                    sel_setor <= '0;
                    timer     <= '0;
                    if (iniciar) begin
                        estado <= Solicita;
                        req    <= 1'b1;
                    end
                end

                Solicita: begin
                    if (ack) begin
                        temp_cap    <= temp;
                        pressao_cap <= pressao;
                        rad_cap     <= radiacao;
                        valido      <= 1'b1;
                        req         <= 1'b0;
                        estado      <= Avalia;
                    end else if (timer == TIMER_FIM) begin
                        falha_setor[sel_setor] <= 1'b1;
                        valido                 <= 1'b0;
                        req                    <= 1'b0;
                        estado                 <= Avalia;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                Avalia: begin
                    // A timed-out sample leaves the counter untouched.
                    if (valido) begin
                        if (excede) begin
                            cnt[sel_setor] <= cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                alarme_setor[sel_setor] <= 1'b1;
                            end
                        end else begin
                            cnt[sel_setor] <= '0;
                        end
                    end

                    timer <= '0;
                    if (sel_setor == ULTIMO_SETOR) begin
                        sel_setor          <= '0;
                        varredura_completa <= 1'b1;
                    end else begin
                        sel_setor <= sel_setor + SW'(1);
                    end

                    if (iniciar) begin
                        estado <= Solicita;
                        req    <= 1'b1;
                    end else begin
                        estado    <= Ocioso;
                        req       <= 1'b0;
                        sel_setor <= '0;
                    end
                end

                default: begin
                    estado <= Ocioso;
                    req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varredura_setores.sv
// ---------------------------------------------------------------------------
// tb_varredura_setores
//
// Self-checking bench for varredura_setores. The bench acts as the sector
// sensor multiplexer and keeps a per-sector model (counters, alarm and fault
// flags, expected sector index) updated once per handshake.
// ---------------------------------------------------------------------------
module tb_varredura_setores;

    localparam int NS       = 4;
    localparam int SWB      = 2;
    localparam int CONFIRMA = 3;
    localparam int TIMEOUT  = 15;

    logic            clk;
    logic            rst_n;
    logic            iniciar;
    logic            req;
    logic [SWB-1:0]  sel_setor;
    logic            ack;
    logic [7:0]      temp;
    logic [3:0]      pressao;
    logic [11:0]     radiacao;
    logic            reconhecer;
    logic [NS-1:0]   alarme_setor;
    logic [NS-1:0]   falha_setor;
    logic            alarme_sonoro;
    logic            varredura_completa;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int            m_cnt [NS];
    logic [NS-1:0] m_alarm;
    logic [NS-1:0] m_fault;
    int            exp_sel;

    varredura_setores #(
        .NUM_SETORES(NS),
        .LIM_TEMP   (40),
        .LIM_PRESSAO(7),
        .LIM_RAD    (1000),
        .CONFIRMA   (CONFIRMA),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .iniciar           (iniciar),
        .req               (req),
        .sel_setor         (sel_setor),
        .ack               (ack),
        .temp              (temp),
        .pressao           (pressao),
        .radiacao          (radiacao),
        .reconhecer        (reconhecer),
        .alarme_setor      (alarme_setor),
        .falha_setor       (falha_setor),
        .alarme_sonoro     (alarme_sonoro),
        .varredura_completa(varredura_completa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) m_cnt[s] = 0;
        m_alarm = '0;
        m_fault = '0;
        exp_sel = 0;
    endfunction

    task automatic do_reset(input int cycles);
        rst_n      = 1'b0;
        iniciar    = 1'b0;
        ack        = 1'b0;
        reconhecer = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One complete sector handshake plus evaluation, checked against the model.
    task automatic visit(input int d, input bit noack, input logic [7:0] t,
                         input logic [3:0] p, input logic [11:0] r,
                         input bit rec, input bit keep);
        int w;
        int n;
        int nc;
        int n_exp;
        bit ex;
        bit last;
        iniciar = 1'b1;
        w = 0;
        while (req !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (req !== 1'b1) $display("FAIL req_wait: req=%b after %0d cycles, want 1", req, w);
        else passed++;
        total++;
        if (sel_setor !== SWB'(exp_sel))
            $display("FAIL sel_req: sel_setor=%0d want %0d", sel_setor, exp_sel);
        else passed++;

        iniciar = keep;
        n = 0;
        while (req === 1'b1 && n < 300) begin
            temp     = 8'($urandom);
            pressao  = 4'($urandom);
            radiacao = 12'($urandom);
            if (!noack && n == d) begin
                ack      = 1'b1;
                temp     = t;
                pressao  = p;
                radiacao = r;
            end
            @(negedge clk);
            ack = 1'b0;
            n++;
        end
        n_exp = noack ? TIMEOUT : d + 1;
        total++;
        if (n !== n_exp) $display("FAIL req_cycles: req high %0d cycles want %0d", n, n_exp);
        else passed++;

        if (noack) m_fault[exp_sel] = 1'b1;
        if (rec) begin
            m_fault = '0;
            for (int s = 0; s < NS; s++) if (m_cnt[s] < CONFIRMA) m_alarm[s] = 1'b0;
        end
        if (!noack) begin
            ex = (int'(t) >= 40) || (int'(p) >= 7) || (int'(r) >= 1000);
            if (ex) begin
                nc = (m_cnt[exp_sel] + 1 > CONFIRMA) ? CONFIRMA : m_cnt[exp_sel] + 1;
                m_cnt[exp_sel] = nc;
                if (nc == CONFIRMA) m_alarm[exp_sel] = 1'b1;
            end else begin
                m_cnt[exp_sel] = 0;
            end
        end
        last    = (exp_sel == NS - 1);
        exp_sel = keep ? (exp_sel + 1) % NS : 0;

        reconhecer = rec;
        @(negedge clk);
        reconhecer = 1'b0;

        total++;
        if (alarme_setor !== m_alarm)
            $display("FAIL alarme_setor: got %b want %b", alarme_setor, m_alarm);
        else passed++;
        total++;
        if (falha_setor !== m_fault)
            $display("FAIL falha_setor: got %b want %b", falha_setor, m_fault);
        else passed++;
        total++;
        if (alarme_sonoro !== ((|m_alarm) | (|m_fault)))
            $display("FAIL alarme_sonoro: got %b want %b", alarme_sonoro,
                     (|m_alarm) | (|m_fault));
        else passed++;
        total++;
        if (varredura_completa !== last)
            $display("FAIL varredura_completa: got %b want %b", varredura_completa, last);
        else passed++;
        total++;
        if ({req, sel_setor} !== {keep, SWB'(exp_sel)})
            $display("FAIL next_sel: req=%b sel=%0d want req=%b sel=%0d", req, sel_setor,
                     keep, exp_sel);
        else passed++;
    endtask

    // Full scan starting at sector 0; sector 'hot' gets (t,p,r), others are clean.
    task automatic scan(input int d, input int hot, input logic [7:0] t,
                        input logic [3:0] p, input logic [11:0] r, input bit keep_last);
        for (int s = 0; s < NS; s++) begin
            if (s == hot) visit(d, 1'b0, t, p, r, 1'b0, (s == NS - 1) ? keep_last : 1'b1);
            else visit(d, 1'b0, 8'd39, 4'd6, 12'd999, 1'b0, (s == NS - 1) ? keep_last : 1'b1);
        end
    endtask

    // Operator acknowledge while idle (no evaluation in the same cycle).
    task automatic pulse_rec();
        reconhecer = 1'b1;
        m_fault    = '0;
        for (int s = 0; s < NS; s++) if (m_cnt[s] < CONFIRMA) m_alarm[s] = 1'b0;
        @(negedge clk);
        reconhecer = 1'b0;
        total++;
        if ({alarme_setor, falha_setor} !== {m_alarm, m_fault})
            $display("FAIL rec_idle: alarme=%b falha=%b want alarme=%b falha=%b",
                     alarme_setor, falha_setor, m_alarm, m_fault);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({req, sel_setor, alarme_setor, falha_setor, alarme_sonoro,
                 varredura_completa} !== '0)
                $display("FAIL reset_idle: cycle %0d req=%b sel=%0d alarme=%b falha=%b son=%b comp=%b want all 0",
                         i, req, sel_setor, alarme_setor, falha_setor, alarme_sonoro,
                         varredura_completa);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_clean_scan();
        do_reset(2);
        scan(1, -1, 8'd39, 4'd6, 12'd999, 1'b1);
        scan(0, -1, 8'd39, 4'd6, 12'd999, 1'b0);
        total++;
        if ({alarme_setor, falha_setor} !== '0)
            $display("FAIL clean_flags: alarme=%b falha=%b want 0", alarme_setor, falha_setor);
        else passed++;
    endtask

    task automatic test_confirm();
        do_reset(2);
        scan(0, 2, 8'd40, 4'd6, 12'd999, 1'b1);
        scan(1, 2, 8'd40, 4'd6, 12'd999, 1'b1);
        total++;
        if (alarme_setor !== 4'b0000)
            $display("FAIL confirm_2scans: alarme=%b want 0000", alarme_setor);
        else passed++;
        scan(2, 2, 8'd40, 4'd6, 12'd999, 1'b0);
        total++;
        if ({alarme_setor, alarme_sonoro} !== {4'b0100, 1'b1})
            $display("FAIL confirm_3scans: alarme=%b son=%b want 0100 1", alarme_setor,
                     alarme_sonoro);
        else passed++;

        do_reset(2);
        scan(0, 2, 8'd39, 4'd6, 12'd1000, 1'b1);
        scan(0, 2, 8'd39, 4'd6, 12'd1000, 1'b1);
        scan(0, 2, 8'd39, 4'd6, 12'd999, 1'b0);
        total++;
        if (alarme_setor !== 4'b0000)
            $display("FAIL confirm_broken: alarme=%b want 0000", alarme_setor);
        else passed++;
    endtask

    task automatic test_ack();
        do_reset(2);
        scan(0, 2, 8'd50, 4'd0, 12'd0, 1'b1);
        scan(0, 2, 8'd50, 4'd0, 12'd0, 1'b1);
        scan(0, 2, 8'd50, 4'd0, 12'd0, 1'b0);
        pulse_rec();
        total++;
        if (alarme_setor !== 4'b0100)
            $display("FAIL ack_held: alarme=%b want 0100", alarme_setor);
        else passed++;
        scan(1, 2, 8'd10, 4'd0, 12'd0, 1'b0);
        pulse_rec();
        total++;
        if ({alarme_setor, alarme_sonoro} !== 5'b0)
            $display("FAIL ack_cleared: alarme=%b son=%b want 0000 0", alarme_setor,
                     alarme_sonoro);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset(2);
        visit(0, 1'b0, 8'd39, 4'd6, 12'd999, 1'b0, 1'b1);
        visit(0, 1'b1, 8'd0, 4'd0, 12'd0, 1'b0, 1'b1);
        total++;
        if (falha_setor !== 4'b0010)
            $display("FAIL timeout_flag: falha=%b want 0010", falha_setor);
        else passed++;
        visit(0, 1'b0, 8'd39, 4'd6, 12'd999, 1'b0, 1'b1);
        visit(2, 1'b0, 8'd39, 4'd6, 12'd999, 1'b0, 1'b0);
        pulse_rec();
        total++;
        if (falha_setor !== 4'b0000)
            $display("FAIL timeout_rec: falha=%b want 0000", falha_setor);
        else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset(2);
        scan(0, 3, 8'd45, 4'd0, 12'd0, 1'b1);
        scan(0, 3, 8'd45, 4'd0, 12'd0, 1'b1);
        for (int s = 0; s < NS - 1; s++) visit(0, 1'b0, 8'd39, 4'd6, 12'd999, 1'b0, 1'b1);
        total++;
        if ({req, sel_setor} !== {1'b1, 2'd3})
            $display("FAIL mid_before: req=%b sel=%0d want 1 3", req, sel_setor);
        else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({req, sel_setor, alarme_setor, falha_setor} !== '0)
            $display("FAIL mid_reset: req=%b sel=%0d alarme=%b falha=%b want all 0", req,
                     sel_setor, alarme_setor, falha_setor);
        else passed++;
        rst_n = 1'b1;
        model_clear();
        scan(1, 3, 8'd45, 4'd0, 12'd0, 1'b1);
        scan(1, 3, 8'd45, 4'd0, 12'd0, 1'b1);
        total++;
        if (alarme_setor !== 4'b0000)
            $display("FAIL mid_fresh2: alarme=%b want 0000", alarme_setor);
        else passed++;
        scan(1, 3, 8'd45, 4'd0, 12'd0, 1'b0);
        total++;
        if (alarme_setor !== 4'b1000)
            $display("FAIL mid_fresh3: alarme=%b want 1000", alarme_setor);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0]  t;
        logic [3:0]  p;
        logic [11:0] r;
        do_reset(2);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                t = 8'($urandom_range(0, 39));
                p = 4'($urandom_range(0, 6));
                r = 12'($urandom_range(0, 999));
            end else begin
                t = 8'($urandom_range(36, 44));
                p = 4'($urandom_range(4, 8));
                r = 12'($urandom_range(996, 1004));
            end
            visit(int'($urandom_range(0, TIMEOUT - 1)), ($urandom_range(0, 9) == 0), t, p, r,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) != 0));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        iniciar    = 1'b0;
        ack        = 1'b0;
        reconhecer = 1'b0;
        temp       = '0;
        pressao    = '0;
        radiacao   = '0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_clean_scan();
        test_confirm();
        test_ack();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
